// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, opcodes, decode predicates and ID FSM states
package cpu_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [3:0] OP_ALU  = 4'h0;
    localparam logic [3:0] OP_MUL  = 4'h1;
    localparam logic [3:0] OP_DIV  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_BGT  = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [AW-1:0] R15 = 4'd15;

    typedef enum logic {RUN, STALL} id_state_t;

    // Opcodes whose second source register (ifInstr[7:4]) is actually read
    function automatic logic op_r2use(input logic [3:0] op);
        return op inside {OP_ALU, OP_MUL, OP_DIV, OP_SW};
    endfunction

    // Opcodes whose operand B is the sign-extended 4-bit immediate
    function automatic logic op_imm(input logic [3:0] op);
        return op inside {OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID, regfile, WB and ID/EX signals of the decode stage
interface id_stage_if;
    import cpu_pkg::*;

    logic [DW-1:0] ifInstr;
    logic          ifValid;
    logic          flush;
    logic          exBusy;
    logic [AW-1:0] regR1;
    logic [AW-1:0] regR2;
    logic [DW-1:0] rdR1;
    logic [DW-1:0] rdR2;
    logic [DW-1:0] rdR15;
    logic          wbWr;
    logic [AW-1:0] wbDst;
    logic [DW-1:0] wbData;
    logic          idStall;
    logic          exValid;
    logic [3:0]    exOp;
    logic [AW-1:0] exDst;
    logic [3:0]    exFunct;
    logic [DW-1:0] exOpA;
    logic [DW-1:0] exOpB;
    logic [DW-1:0] exR15;
    logic          exMemRd;
    logic          exWr;
    logic          exWrR15;

    modport master (
        output ifInstr, ifValid, flush, exBusy, rdR1, rdR2, rdR15, wbWr, wbDst, wbData,
        input  regR1, regR2, idStall, exValid, exOp, exDst, exFunct,
               exOpA, exOpB, exR15, exMemRd, exWr, exWrR15
    );

    modport slave (
        input  ifInstr, ifValid, flush, exBusy, rdR1, rdR2, rdR15, wbWr, wbDst, wbData,
        output regR1, regR2, idStall, exValid, exOp, exDst, exFunct,
               exOpA, exOpB, exR15, exMemRd, exWr, exWrR15
    );

endinterface

// File: rtl/id_decode.sv
// id_decode: opcode to write/load control bits; undefined opcodes decode as NOP
module id_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    output logic       wr,
    output logic       wr15,
    output logic       mem_rd
);

    // Control-bit table: only register-writing ops set wr, MUL/DIV also write R15
    always_comb begin
        wr     = 1'b0;
        wr15   = 1'b0;
        mem_rd = 1'b0;
        case (op)
            OP_ALU, OP_ADDI: wr = 1'b1;
            OP_MUL, OP_DIV: begin
                wr   = 1'b1;
                wr15 = 1'b1;
            end
            OP_LW: begin
                wr     = 1'b1;
                mem_rd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode, load-use interlock FSM and ID/EX pipeline register.
// Optional WB->ID operand bypass is enabled by defining ID_WB_BYPASS_EN.
module id_stage
    import cpu_pkg::*;
#(
    parameter int LU_STALL = 1
)(
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    localparam logic [1:0] CNT_INIT = 2'(LU_STALL - 1);

    id_state_t     state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic [3:0]    op;
    logic          wr, wr15, mem_rd;
    logic          hz, capture, kill;
    logic [DW-1:0] rd_a, rd_b, rd_r15, op_b;

    assign op        = bus.ifInstr[15:12];
    assign bus.regR1 = bus.ifInstr[11:8];
    assign bus.regR2 = bus.ifInstr[7:4];

    id_decode u_dec (
        .op     (op),
        .wr     (wr),
        .wr15   (wr15),
        .mem_rd (mem_rd)
    );

`ifdef ID_WB_BYPASS_EN
    assign rd_a   = (bus.wbWr && bus.wbDst == bus.regR1) ? bus.wbData : bus.rdR1;
    assign rd_b   = (bus.wbWr && bus.wbDst == bus.regR2) ? bus.wbData : bus.rdR2;
    assign rd_r15 = (bus.wbWr && bus.wbDst == R15) ? bus.wbData : bus.rdR15;
`else
    assign rd_a   = bus.rdR1;
    assign rd_b   = bus.rdR2;
    assign rd_r15 = bus.rdR15;
`endif

    assign op_b = op_imm(op) ? {{(DW-4){bus.ifInstr[3]}}, bus.ifInstr[3:0]} : rd_b;

    // A load in EX whose destination is a source of the instruction in ID
    assign hz = bus.ifValid & bus.exValid & bus.exMemRd &
                ((bus.exDst == bus.regR1) | (op_r2use(op) & (bus.exDst == bus.regR2)));

    // Interlock next-state and stage controls: flush > exBusy > hazard > normal
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bus.idStall = 1'b0;
        capture     = 1'b0;
        kill        = 1'b0;
        if (bus.flush) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
            kill      = 1'b1;
        end else if (state == STALL) begin
            bus.idStall = 1'b1;
            kill        = 1'b1;
            cnt_nxt     = cnt - 2'd1;
            state_nxt   = (cnt == 2'd1) ? RUN : STALL;
        end else if (bus.exBusy) begin
            bus.idStall = 1'b1;
        end else if (hz) begin
            bus.idStall = 1'b1;
            kill        = 1'b1;
            cnt_nxt     = CNT_INIT;
            state_nxt   = (LU_STALL > 1) ? STALL : RUN;
        end else begin
            capture = 1'b1;
        end
    end

    // FSM state and ID/EX register: bubbles clear valid/controls, exBusy holds everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            cnt         <= 2'd0;
            bus.exValid <= 1'b0;
            bus.exOp    <= '0;
            bus.exDst   <= '0;
            bus.exFunct <= '0;
            bus.exOpA   <= '0;
            bus.exOpB   <= '0;
            bus.exR15   <= '0;
            bus.exMemRd <= 1'b0;
            bus.exWr    <= 1'b0;
            bus.exWrR15 <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (kill) begin
                bus.exValid <= 1'b0;
                bus.exMemRd <= 1'b0;
                bus.exWr    <= 1'b0;
                bus.exWrR15 <= 1'b0;
            end else if (capture) begin
                bus.exValid <= bus.ifValid;
                bus.exOp    <= op;
                bus.exDst   <= bus.regR1;
                bus.exFunct <= bus.ifInstr[3:0];
                bus.exOpA   <= rd_a;
                bus.exOpB   <= op_b;
                bus.exR15   <= rd_r15;
                bus.exMemRd <= bus.ifValid & mem_rd;
                bus.exWr    <= bus.ifValid & wr;
                bus.exWrR15 <= bus.ifValid & wr15;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage with LU_STALL=1 (u1) and LU_STALL=3 (u3)
module tb_id_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    id_stage_if b1();
    id_stage_if b3();

    assign b3.ifInstr = b1.ifInstr;
    assign b3.ifValid = b1.ifValid;
    assign b3.flush   = b1.flush;
    assign b3.exBusy  = b1.exBusy;
    assign b3.rdR1    = b1.rdR1;
    assign b3.rdR2    = b1.rdR2;
    assign b3.rdR15   = b1.rdR15;
    assign b3.wbWr    = b1.wbWr;
    assign b3.wbDst   = b1.wbDst;
    assign b3.wbData  = b1.wbData;

    id_stage #(.LU_STALL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    id_stage #(.LU_STALL(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        b1.ifInstr = 16'h0120; b1.ifValid = 1'b1; b1.flush = 1'b0; b1.exBusy = 1'b0;
        b1.rdR1 = 16'hFFFF; b1.rdR2 = 16'h0050; b1.rdR15 = 16'hABCD;
        b1.wbWr = 1'b0; b1.wbDst = 4'd0; b1.wbData = 16'h0000;
        #1 rst = 1'b0;
        tick; tick;
        total++; if ({b1.exValid, b1.exWr, b1.exOpA, b3.exValid} !== 19'd0) $display("FAIL reset_regs got %h exp 0", {b1.exValid, b1.exWr, b1.exOpA, b3.exValid}); else passed++;
        total++; if ({b1.regR1, b1.regR2} !== 8'h12) $display("FAIL reg_addr got %h exp 12", {b1.regR1, b1.regR2}); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({b1.exValid, b1.idStall} !== 2'b00) $display("FAIL post_reset got %b exp 00", {b1.exValid, b1.idStall}); else passed++;
        tick;
        total++; if ({b1.exValid, b1.exOp, b1.exWr} !== 6'b1_0000_1) $display("FAIL first_ctrl got %b exp 100001", {b1.exValid, b1.exOp, b1.exWr}); else passed++;
        total++; if ({b1.exOpA, b1.exOpB, b1.exR15} !== {16'hFFFF, 16'h0050, 16'hABCD}) $display("FAIL first_ops got %h exp ffff0050abcd", {b1.exOpA, b1.exOpB, b1.exR15}); else passed++;
    endtask

    task automatic test_load_use;
        b1.ifInstr = 16'h8500;
        tick;
        total++; if ({b1.exValid, b1.exMemRd, b1.exWr, b1.exDst} !== 7'b111_0101) $display("FAIL lw_capture got %b exp 1110101", {b1.exValid, b1.exMemRd, b1.exWr, b1.exDst}); else passed++;
        b1.ifInstr = 16'h0350; b1.rdR2 = 16'h0077;
        #1;
        total++; if (b1.idStall !== 1'b1) $display("FAIL lu_stall got %b exp 1", b1.idStall); else passed++;
        tick;
        total++; if ({b1.exValid, b1.exMemRd, b1.exWr, b1.idStall} !== 4'b0000) $display("FAIL lu_bubble got %b exp 0000", {b1.exValid, b1.exMemRd, b1.exWr, b1.idStall}); else passed++;
        tick;
        total++; if ({b1.exValid, b1.exDst, b1.exOpB} !== {1'b1, 4'd3, 16'h0077}) $display("FAIL lu_resume got %h exp 130077", {b1.exValid, b1.exDst, b1.exOpB}); else passed++;
        total++; if (b3.idStall !== 1'b1) $display("FAIL lu3_in_stall got %b exp 1", b3.idStall); else passed++;
        rst = 1'b0;
        #1;
        total++; if ({b3.idStall, b3.exValid} !== 2'b00) $display("FAIL reset_mid_stall got %b exp 00", {b3.idStall, b3.exValid}); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_stall3;
        int n;
        n = 0;
        b1.ifInstr = 16'h8500;
        tick;
        b1.ifInstr = 16'h0350;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (b3.idStall === 1'b1) n++;
            tick;
        end
        total++; if (n !== 3) $display("FAIL lu3_stall_cycles got %0d exp 3", n); else passed++;
        total++; if ({b3.exValid, b3.exDst, b3.idStall} !== 6'b1_0011_0) $display("FAIL lu3_resume got %b exp 100110", {b3.exValid, b3.exDst, b3.idStall}); else passed++;
    endtask

    task automatic test_flush;
        b1.ifInstr = 16'h8500;
        tick;
        b1.ifInstr = 16'h0350;
        #1;
        total++; if (b3.idStall !== 1'b1) $display("FAIL fl_hz got %b exp 1", b3.idStall); else passed++;
        tick;
        total++; if ({b3.idStall, b3.exValid} !== 2'b10) $display("FAIL fl_stall2 got %b exp 10", {b3.idStall, b3.exValid}); else passed++;
        b1.flush = 1'b1;
        #1;
        total++; if (b3.idStall !== 1'b0) $display("FAIL fl_nostall got %b exp 0", b3.idStall); else passed++;
        tick;
        b1.flush = 1'b0;
        #1;
        total++; if ({b3.exValid, b3.idStall} !== 2'b00) $display("FAIL fl_run got %b exp 00", {b3.exValid, b3.idStall}); else passed++;
        tick;
        total++; if ({b3.exValid, b3.exDst} !== 5'b1_0011) $display("FAIL fl_resume got %b exp 10011", {b3.exValid, b3.exDst}); else passed++;
    endtask

    task automatic test_busy;
        logic [63:0] exp_b;
        b1.ifInstr = 16'h1123; b1.rdR1 = 16'h1111; b1.rdR2 = 16'h2222; b1.rdR15 = 16'h5555;
        tick;
        exp_b = {1'b1, 4'h1, 4'h1, 4'h3, 16'h1111, 16'h2222, 16'h5555, 1'b0, 1'b1, 1'b1};
        b1.exBusy = 1'b1; b1.ifInstr = 16'h0450;
        b1.rdR1 = 16'hAAAA; b1.rdR2 = 16'hBBBB; b1.rdR15 = 16'hCCCC;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (b1.idStall !== 1'b1) $display("FAIL busy_stall[%0d] got %b exp 1", i, b1.idStall); else passed++;
            tick;
            total++; if ({b1.exValid, b1.exOp, b1.exDst, b1.exFunct, b1.exOpA, b1.exOpB, b1.exR15, b1.exMemRd, b1.exWr, b1.exWrR15} !== exp_b)
                $display("FAIL busy_hold[%0d] got %h exp %h", i, {b1.exValid, b1.exOp, b1.exDst, b1.exFunct, b1.exOpA, b1.exOpB, b1.exR15, b1.exMemRd, b1.exWr, b1.exWrR15}, exp_b); else passed++;
        end
        b1.exBusy = 1'b0;
        #1;
        total++; if (b1.idStall !== 1'b0) $display("FAIL busy_release got %b exp 0", b1.idStall); else passed++;
        tick;
        total++; if ({b1.exOp, b1.exDst, b1.exOpA, b1.exOpB, b1.exWrR15} !== {4'h0, 4'h4, 16'hAAAA, 16'hBBBB, 1'b0}) $display("FAIL busy_resume got %h exp 04aaaabbbb0", {b1.exOp, b1.exDst, b1.exOpA, b1.exOpB, b1.exWrR15}); else passed++;
    endtask

    task automatic test_decode;
        b1.ifInstr = 16'h3A2E;
        tick;
        total++; if ({b1.exOp, b1.exDst, b1.exOpB} !== {4'h3, 4'hA, 16'hFFFE}) $display("FAIL addi_ops got %h exp 3afffe", {b1.exOp, b1.exDst, b1.exOpB}); else passed++;
        total++; if ({b1.exWr, b1.exMemRd, b1.exWrR15} !== 3'b100) $display("FAIL addi_ctrl got %b exp 100", {b1.exWr, b1.exMemRd, b1.exWrR15}); else passed++;
        b1.ifInstr = 16'h7123;
        tick;
        total++; if ({b1.exValid, b1.exWr, b1.exWrR15, b1.exMemRd} !== 4'b1000) $display("FAIL undef_nop got %b exp 1000", {b1.exValid, b1.exWr, b1.exWrR15, b1.exMemRd}); else passed++;
        b1.ifInstr = 16'h8503;
        tick;
        total++; if ({b1.exOpB, b1.exMemRd, b1.exWr} !== {16'h0003, 2'b11}) $display("FAIL lw_imm got %h exp 3 ctl 11", {b1.exOpB, b1.exMemRd, b1.exWr}); else passed++;
        b1.ifValid = 1'b0; b1.ifInstr = 16'h0350;
        #1;
        total++; if (b1.idStall !== 1'b0) $display("FAIL invalid_nohz got %b exp 0", b1.idStall); else passed++;
        tick;
        total++; if ({b1.exValid, b1.exWr} !== 2'b00) $display("FAIL invalid_cap got %b exp 00", {b1.exValid, b1.exWr}); else passed++;
        b1.ifValid = 1'b1; b1.ifInstr = 16'h4350;
        tick;
        total++; if ({b1.exValid, b1.exOp, b1.exWr} !== 6'b1_0100_0) $display("FAIL beq_ctrl got %b exp 101000", {b1.exValid, b1.exOp, b1.exWr}); else passed++;
    endtask

    task automatic test_bypass;
        logic [15:0] exp_b, exp_r15;
`ifdef ID_WB_BYPASS_EN
        exp_b = 16'h1234; exp_r15 = 16'h1234;
`else
        exp_b = 16'h0050; exp_r15 = 16'h0F0F;
`endif
        b1.ifInstr = 16'h0020; b1.rdR1 = 16'h0101; b1.rdR2 = 16'h0050; b1.rdR15 = 16'h0F0F;
        b1.wbWr = 1'b1; b1.wbDst = 4'd2; b1.wbData = 16'h1234;
        tick;
        total++; if ({b1.exOpA, b1.exOpB} !== {16'h0101, exp_b}) $display("FAIL bypass_opb got %h exp %h", {b1.exOpA, b1.exOpB}, {16'h0101, exp_b}); else passed++;
        b1.wbDst = 4'd15;
        tick;
        total++; if ({b1.exOpB, b1.exR15} !== {16'h0050, exp_r15}) $display("FAIL bypass_r15 got %h exp %h", {b1.exOpB, b1.exR15}, {16'h0050, exp_r15}); else passed++;
        b1.wbWr = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_stall3;
        test_flush;
        test_busy;
        test_decode;
        test_bypass;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
